// File: rtl/gate_equiv_sequencer.sv
// gate_equiv_sequencer: walks every input pattern of an N_IN-input gate pair,
// holds each pattern for SETTLE+1 cycles, compares the two responses in the
// last cycle of each pattern, and reports a mismatch count, the first failing
// pattern and a one-cycle done pulse carrying the pass verdict.
module gate_equiv_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  x,
    input  logic             a_in,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Hold counter must be at least one bit wide even when SETTLE is zero.
    localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [HW-1:0]    HOLD_INIT = HW'(SETTLE);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0]    HOLD_ZERO = HW'(0);
    localparam logic [N_IN-1:0]  X_ZERO    = N_IN'(0);
    localparam logic [N_IN-1:0]  X_ONE     = N_IN'(1);
    localparam logic [N_IN-1:0]  X_LAST    = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t          state_r, state_s;
    logic [HW-1:0]    hold_cnt_r, hold_cnt_s;
    logic [N_IN-1:0]  x_s;
    logic             busy_s, done_s, pass_s, first_fail_valid_s;
    logic [CNT_W-1:0] err_count_s;
    logic [N_IN-1:0]  first_fail_s;
    logic             mismatch_s;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s             = state_r;
        hold_cnt_s          = hold_cnt_r;
        x_s                 = x;
        busy_s              = busy;
        done_s              = 1'b0;
        pass_s              = pass;
        err_count_s         = err_count;
        first_fail_s        = first_fail;
        first_fail_valid_s  = first_fail_valid;
        mismatch_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s            = ST_HOLD;
                    x_s                = X_ZERO;
                    hold_cnt_s         = HOLD_INIT;
                    err_count_s        = CNT_ZERO;
                    first_fail_s       = X_ZERO;
                    first_fail_valid_s = 1'b0;
                    pass_s             = 1'b0;
                    busy_s             = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r != HOLD_ZERO) begin
                    hold_cnt_s = hold_cnt_r - HOLD_ONE;
                end else begin
                    // Case inequality so an X/Z response is treated as a mismatch.
                    mismatch_s = (a_in !== b_in);
                    if (mismatch_s) begin
                        err_count_s = sat_inc(err_count);
                        if (!first_fail_valid) begin
                            first_fail_s       = x;
                            first_fail_valid_s = 1'b1;
                        end else begin
                            first_fail_s       = first_fail;
                            first_fail_valid_s = first_fail_valid;
                        end
                    end else begin
                        err_count_s = err_count;
                    end
                    if (x == X_LAST) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        pass_s  = (err_count_s == CNT_ZERO);
                    end else begin
                        x_s        = x + X_ONE;
                        hold_cnt_s = HOLD_INIT;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            hold_cnt_r       <= HOLD_ZERO;
            x                <= X_ZERO;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= CNT_ZERO;
            first_fail       <= X_ZERO;
            first_fail_valid <= 1'b0;
        end else begin
            state_r          <= state_s;
            hold_cnt_r       <= hold_cnt_s;
            x                <= x_s;
            busy             <= busy_s;
            done             <= done_s;
            pass             <= pass_s;
            err_count        <= err_count_s;
            first_fail       <= first_fail_s;
            first_fail_valid <= first_fail_valid_s;
        end
    end

endmodule
